// File: rtl/rsa_timing_probe.sv
// rsa_timing_probe: request FIFO, launch sequencer and cycle-accurate latency
// probe wrapped around an RSA_decrypt core. Requests (c, d, n) are queued,
// launched one at a time with a single-cycle start pulse, and the plaintext is
// returned with the number of cycles between the start sample and the first
// finish sample.
//
// Optional feature macro: RSA_PROBE_TIMEOUT_EN
//   When defined, a request whose core does not finish within TIMEOUT cycles
//   is answered with rsp_timeout=1, and the late finish is drained afterwards.
module rsa_timing_probe #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_c,
  input  logic [15:0]      req_d,
  input  logic [15:0]      req_n,
  output logic             dec_start,
  output logic [15:0]      dec_c,
  output logic [15:0]      dec_d,
  output logic [15:0]      dec_n,
  input  logic [15:0]      dec_m,
  input  logic             dec_finish,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_m,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             rsp_timeout
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  // Saturating increment: the latency counter must never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [15:0] fifo_c [DEPTH];
  logic [15:0] fifo_d [DEPTH];
  logic [15:0] fifo_n [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_c[wr_ptr[AW-1:0]] <= req_c;
      fifo_d[wr_ptr[AW-1:0]] <= req_d;
      fifo_n[wr_ptr[AW-1:0]] <= req_n;
    end
  end

  // FIFO pointers; reset discards any queued requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef RSA_PROBE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  logic tmo_q;
  logic late_fin;

  assign rsp_timeout = tmo_q;

  // Launch/measure/respond sequencer with timeout abort and late-finish drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dec_start  <= 1'b0;
      dec_c      <= '0;
      dec_d      <= '0;
      dec_n      <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_m      <= '0;
      rsp_cycles <= '0;
      tmo_q      <= 1'b0;
      late_fin   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dec_start <= 1'b0;
          if (!empty) begin
            dec_c <= fifo_c[rd_ptr[AW-1:0]];
            dec_d <= fifo_d[rd_ptr[AW-1:0]];
            dec_n <= fifo_n[rd_ptr[AW-1:0]];
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          dec_start <= 1'b1;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          dec_start <= 1'b0;
          // The start-sample edge itself is cycle zero; finish cannot
          // belong to this request yet, so hold the count and ignore it.
          if (dec_start) begin
            cnt <= cnt;
          end else if (dec_finish) begin
            rsp_m      <= dec_m;
            rsp_cycles <= sat_inc(cnt);
            tmo_q      <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (cnt == TMO_VAL) begin
            rsp_m      <= '0;
            rsp_cycles <= TMO_VAL;
            tmo_q      <= 1'b1;
            late_fin   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_RESP: begin
          // A finish that shows up while the timeout response waits must
          // still release the drain afterwards.
          if (tmo_q && dec_finish) late_fin <= 1'b1;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= tmo_q ? S_DRAIN : S_IDLE;
          end
        end
        S_DRAIN: begin
          if (dec_finish || late_fin) begin
            late_fin <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          dec_start <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
`else
  logic [31:0] tmo_param;
  logic        unused_tmo;

  assign tmo_param   = TIMEOUT;
  assign unused_tmo  = ^tmo_param;
  assign rsp_timeout = 1'b0;

  // Launch/measure/respond sequencer; a hung core simply saturates the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dec_start  <= 1'b0;
      dec_c      <= '0;
      dec_d      <= '0;
      dec_n      <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_m      <= '0;
      rsp_cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          dec_start <= 1'b0;
          if (!empty) begin
            dec_c <= fifo_c[rd_ptr[AW-1:0]];
            dec_d <= fifo_d[rd_ptr[AW-1:0]];
            dec_n <= fifo_n[rd_ptr[AW-1:0]];
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          dec_start <= 1'b1;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          dec_start <= 1'b0;
          // The start-sample edge itself is cycle zero; finish cannot
          // belong to this request yet, so hold the count and ignore it.
          if (dec_start) begin
            cnt <= cnt;
          end else if (dec_finish) begin
            rsp_m      <= dec_m;
            rsp_cycles <= sat_inc(cnt);
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          dec_start <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rsa_timing_probe.sv
// Scoreboard bench for rsa_timing_probe with a behavioural RSA core stub.
module tb_rsa_timing_probe;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_c;
  logic [15:0] req_d;
  logic [15:0] req_n;
  logic        dec_start;
  logic [15:0] dec_c;
  logic [15:0] dec_d;
  logic [15:0] dec_n;
  logic [15:0] dec_m;
  logic        dec_finish;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_m;
  logic [31:0] rsp_cycles;
  logic        rsp_timeout;

  rsa_timing_probe #(.DEPTH(4), .CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_c(req_c), .req_d(req_d), .req_n(req_n),
    .dec_start(dec_start), .dec_c(dec_c), .dec_d(dec_d), .dec_n(dec_n),
    .dec_m(dec_m), .dec_finish(dec_finish),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_m(rsp_m), .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] m;
    logic [31:0] cyc;
    logic        tmo;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- behavioural core stub ----------------
  function automatic logic [15:0] modexp(input logic [15:0] c, input logic [15:0] d,
                                         input logic [15:0] n);
    logic [31:0] r;
    logic [31:0] b;
    r = 1;
    b = 32'(c) % 32'(n);
    for (int i = 0; i < 16; i++) begin
      if (d[i]) r = (r * b) % 32'(n);
      b = (b * b) % 32'(n);
    end
    return r[15:0];
  endfunction

  int lat_cfg = 37;
  int hold_cfg = 1;
  int rem = 0;
  bit running = 0;
  int hold_left = 0;
  int edge_no = 0;
  int start_edge = 0;
  int meas = 0;
  bit fin_seen = 0;
  int start_cnt = 0;
  logic [15:0] m_val = 0;
  bit st_s, fin_s, nf_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running = 0;
      hold_left = 0;
      dec_finish = 1'b0;
      dec_m = 16'd0;
    end else begin
      edge_no++;
      st_s = dec_start;
      fin_s = dec_finish;
      nf_s = fin_s;
      if (fin_s) begin
        if (!fin_seen) begin
          meas = edge_no - start_edge;
          fin_seen = 1;
        end
        hold_left--;
        if (hold_left <= 0) nf_s = 0;
      end
      if (st_s) begin
        start_cnt++;
        start_edge = edge_no;
        fin_seen = 0;
        rem = lat_cfg - 1;
        running = 1;
        m_val = modexp(dec_c, dec_d, dec_n);
      end else if (running) begin
        rem--;
        if (rem == 0) begin
          running = 0;
          nf_s = 1;
          hold_left = hold_cfg;
        end
      end
      #1;
      dec_finish = nf_s;
      dec_m = m_val;
    end
  end

  // ---------------- monitor ----------------
  bit          prev_hold = 0;
  logic [15:0] prev_m;
  logic [31:0] prev_cyc;
  logic        prev_tmo;
  bit          prev_start = 0;
  logic [31:0] last_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dec_start && prev_start) chk("start_width", 2, 1);
      if (prev_hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_fields", {rsp_m, rsp_cycles, rsp_timeout}, {prev_m, prev_cyc, prev_tmo});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_m", rsp_m, e.m);
          chk("rsp_cycles", rsp_cycles, e.cyc);
          chk("rsp_timeout", rsp_timeout, e.tmo);
          last_cyc = rsp_cycles;
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_m = rsp_m;
      prev_cyc = rsp_cycles;
      prev_tmo = rsp_timeout;
      prev_start = dec_start;
    end else begin
      prev_hold = 0;
      prev_start = 0;
    end
  end

  // ---------------- stimulus ----------------
  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic push(input logic [15:0] c, input logic [15:0] d, input logic [15:0] n,
                      input logic [15:0] m, input int cyc, input bit tmo);
    int w;
    exp_t e;
    w = 0;
    while (!req_ready && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk("push_ready", req_ready, 1);
    req_valid = 1'b1;
    req_c = c; req_d = d; req_n = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.m = m; e.cyc = cyc; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < max_cycles) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_dec_start"}, dec_start, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_dec_cdn"}, {dec_c, dec_d, dec_n}, 0);
    chk({tag, "_rsp_data"}, {rsp_m, rsp_cycles}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_c = 0; req_d = 0; req_n = 0;
    rsp_ready = 1'b1;
    #7;
    check_reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Classic textbook key: 1394^2011 mod 3127 = 89.
    lat_cfg = 60; hold_cfg = 1;
    push(16'd1394, 16'd2011, 16'd3127, 16'd89, 60, 0);
    wait_drain(500);
    chk("measured_vs_rsp", last_cyc, meas);

    // Three back-to-back requests, fixed latency.
    lat_cfg = 37; start_cnt = 0;
    push(16'd5, 16'd3, 16'd33, 16'd26, 37, 0);
    push(16'd7, 16'd2, 16'd100, 16'd49, 37, 0);
    push(16'd2, 16'd10, 16'd1000, 16'd24, 37, 0);
    wait_drain(1000);
    chk("start_count3", start_cnt, 3);

    // Backpressure: 1 in flight plus 4 queued, then a sixth is refused.
    rsp_ready = 1'b0;
    push(16'd3, 16'd4, 16'd1000, 16'd81, 37, 0);
    push(16'd2, 16'd5, 16'd1000, 16'd32, 37, 0);
    push(16'd4, 16'd3, 16'd1000, 16'd64, 37, 0);
    push(16'd6, 16'd2, 16'd1000, 16'd36, 37, 0);
    push(16'd9, 16'd2, 16'd1000, 16'd81, 37, 0);
    chk("full_ready", req_ready, 0);
    req_valid = 1'b1;
    req_c = 16'd8; req_d = 16'd2; req_n = 16'd1000;
    repeat (100) @(posedge clk);
    #1;
    chk("full_ready_held", req_ready, 0);
    chk("rsp_held_valid", rsp_valid, 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain(2000);

    // Reset while the core is busy.
    lat_cfg = 200;
    push(16'd5, 16'd3, 16'd33, 16'd26, 200, 0);
    push(16'd7, 16'd2, 16'd100, 16'd49, 200, 0);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    start_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_reset_starts", start_cnt, 0);
    chk("post_reset_ready", req_ready, 1);

    // Finish held high for five cycles: one response each, counts unaffected.
    lat_cfg = 20; hold_cfg = 5; start_cnt = 0;
    push(16'd10, 16'd2, 16'd7, 16'd2, 20, 0);
    push(16'd12, 16'd2, 16'd7, 16'd4, 20, 0);
    wait_drain(500);
    chk("start_count2", start_cnt, 2);
    hold_cfg = 1;

`ifdef RSA_PROBE_TIMEOUT_EN
    // Core finishing at 40 against a 16-cycle timeout, then a normal request.
    lat_cfg = 40;
    push(16'd5, 16'd3, 16'd33, 16'd0, 16, 1);
    wait_drain(500);
    lat_cfg = 10;
    push(16'd3, 16'd3, 16'd100, 16'd27, 10, 0);
    wait_drain(500);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
